// File: rtl/uart_bus_master_if.sv
// uart_bus_master_if
//
// Purpose: groups the UART-side byte handshake and the peripheral-bus
// initiator signals of the uart_bus_master debug bridge.
//
// Signals:
//   rx_data, rx_data_fresh       received byte and its single-cycle strobe
//   tx_data, tx_data_valid       byte to transmit and its single-cycle request
//   tx_data_ack                  single-cycle pulse, requested byte finished
//   rdaddress, rden, rdata       bus read port (rdata valid in the rden cycle)
//   wraddress, wdata, wrbyteena,
//   wren                         bus write port
//   busy                         bridge is not idle
//
// Modports:
//   master  the bridge itself
//   slave   the environment (UART core plus bus mux / peripherals)

interface uart_bus_master_if;
    logic [7:0]  rx_data;
    logic        rx_data_fresh;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ack;
    logic [31:0] rdaddress;
    logic        rden;
    logic [31:0] rdata;
    logic [31:0] wraddress;
    logic [31:0] wdata;
    logic [3:0]  wrbyteena;
    logic        wren;
    logic        busy;

    modport master (
        input  rx_data, rx_data_fresh, tx_data_ack, rdata,
        output tx_data, tx_data_valid, rdaddress, rden,
               wraddress, wdata, wrbyteena, wren, busy
    );

    modport slave (
        output rx_data, rx_data_fresh, tx_data_ack, rdata,
        input  tx_data, tx_data_valid, rdaddress, rden,
               wraddress, wdata, wrbyteena, wren, busy
    );
endinterface

// File: rtl/uart_bus_master.sv
// uart_bus_master
//
// Purpose: UART debug bridge. Parses command frames from the UART receiver
// and issues single-word read/write transactions on the peripheral bus,
// then returns read data (4 bytes, LSB first) or a single ACK_BYTE through
// the UART transmitter.
//
// Frames:
//   read : 'R' (8'h52), addr[7:0], addr[15:8], addr[23:16], addr[31:24]
//   write: 'W' (8'h57), 4 address bytes LSB first, 4 data bytes LSB first
//
// Ports:
//   clk     block clock
//   resetn  asynchronous active-low reset
//   bus     uart_bus_master_if.master (UART byte handshake + bus initiator)
//
// Parameters:
//   ACK_BYTE        response byte after a completed write
//   TIMEOUT_CYCLES  inter-byte timeout in clk cycles (optional feature only)
//
// Optional feature: define UART_BUS_MASTER_TIMEOUT_EN to abandon a partial
// frame after TIMEOUT_CYCLES cycles without a new byte in ADDR or DATA.
// Without it a partial frame waits indefinitely.

module uart_bus_master #(
    parameter logic [7:0] ACK_BYTE       = 8'h4B,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input logic               clk,
    input logic               resetn,
    uart_bus_master_if.master bus
);

    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] CMD_WRITE = 8'h57;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("uart_bus_master: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        BUS_RD,
        BUS_WR,
        RESP
    } state_t;

    state_t      state, state_n;
    logic [1:0]  cnt, cnt_n;
    logic [31:0] addr, addr_n;
    logic [31:0] data, data_n;
    logic        is_wr, is_wr_n;
    // Set once the current response byte has been requested and we are
    // waiting for its ack; guarantees no second request before the ack.
    logic        tx_wait, tx_wait_n;

    logic        rden_c;
    logic        wren_c;
    logic        tx_valid_c;
    logic [7:0]  tx_data_c;
    logic        byte_done;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            timed_out;

    // Inter-byte timer: runs only while a frame is being collected and
    // restarts on every byte that arrives there.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            to_cnt <= '0;
        end else if ((state == ADDR) || (state == DATA)) begin
            if (bus.rx_data_fresh) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end else begin
            to_cnt <= '0;
        end
    end

    assign timed_out = ((state == ADDR) || (state == DATA)) &&
                       !bus.rx_data_fresh && (to_cnt == TO_LAST);
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            addr    <= 32'd0;
            data    <= 32'd0;
            is_wr   <= 1'b0;
            tx_wait <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            addr    <= addr_n;
            data    <= data_n;
            is_wr   <= is_wr_n;
            tx_wait <= tx_wait_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        addr_n     = addr;
        data_n     = data;
        is_wr_n    = is_wr;
        tx_wait_n  = tx_wait;
        rden_c     = 1'b0;
        wren_c     = 1'b0;
        tx_valid_c = 1'b0;
        tx_data_c  = 8'h00;
        byte_done  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.rx_data_fresh &&
                    ((bus.rx_data == CMD_READ) || (bus.rx_data == CMD_WRITE))) begin
                    is_wr_n = (bus.rx_data == CMD_WRITE);
                    cnt_n   = 2'd0;
                    state_n = ADDR;
                end
            end

            ADDR: begin
                if (bus.rx_data_fresh) begin
                    addr_n[{cnt, 3'b000} +: 8] = bus.rx_data;
                    cnt_n = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_n = is_wr ? DATA : BUS_RD;
                    end
                end
            end

            DATA: begin
                if (bus.rx_data_fresh) begin
                    data_n[{cnt, 3'b000} +: 8] = bus.rx_data;
                    cnt_n = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_n = BUS_WR;
                    end
                end
            end

            BUS_RD: begin
                rden_c    = 1'b1;
                data_n    = bus.rdata;
                cnt_n     = 2'd0;
                tx_wait_n = 1'b0;
                state_n   = RESP;
            end

            BUS_WR: begin
                wren_c    = 1'b1;
                cnt_n     = 2'd0;
                tx_wait_n = 1'b0;
                state_n   = RESP;
            end

            RESP: begin
                tx_data_c = is_wr ? ACK_BYTE : data[{cnt, 3'b000} +: 8];
                // An ack in the same cycle as the request completes the byte.
                if (!tx_wait) begin
                    tx_valid_c = 1'b1;
                    if (bus.tx_data_ack) begin
                        byte_done = 1'b1;
                    end else begin
                        tx_wait_n = 1'b1;
                    end
                end else if (bus.tx_data_ack) begin
                    byte_done = 1'b1;
                    tx_wait_n = 1'b0;
                end

                if (byte_done) begin
                    if (is_wr || (cnt == 2'd3)) begin
                        cnt_n   = 2'd0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 2'd1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = 2'd0;
            end
        endcase

`ifdef UART_BUS_MASTER_TIMEOUT_EN
        if (timed_out) begin
            state_n = IDLE;
            cnt_n   = 2'd0;
        end
`endif
    end

    // Outputs are decoded from state and cleared registers, so they all drop
    // to zero as soon as resetn is asserted.
    assign bus.rden          = rden_c;
    assign bus.wren          = wren_c;
    assign bus.rdaddress     = addr;
    assign bus.wraddress     = addr;
    assign bus.wdata         = data;
    assign bus.wrbyteena     = wren_c ? 4'hF : 4'h0;
    assign bus.tx_data       = tx_data_c;
    assign bus.tx_data_valid = tx_valid_c;
    assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master
//
// Purpose: self-checking bench for uart_bus_master. Table-driven frames
// (read, write, garbage prefix, same-cycle acks) plus hand-written
// sequences for reset state, byte drop while busy, reset mid-frame and,
// when UART_BUS_MASTER_TIMEOUT_EN is defined, the inter-byte timeout.

module tb_uart_bus_master;

`ifdef UART_BUS_MASTER_TIMEOUT_EN
    localparam int TO_CYC = 100;
`else
    localparam int TO_CYC = 1000000;
`endif

    logic clk;
    logic resetn;

    uart_bus_master_if bus_if ();

    uart_bus_master #(
        .ACK_BYTE       (8'h4B),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bus model: fixed word at 0x20000, otherwise derived from the address.
    assign bus_if.rdata = (bus_if.rdaddress == 32'h0002_0000) ? 32'h0000_00A5
                                                               : {bus_if.rdaddress[15:0], 16'hC0DE};

    // Bus monitor.
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_rdaddr = '0;
    logic [31:0] last_wraddr = '0;
    logic [31:0] last_wdata  = '0;
    logic [3:0]  last_be     = '0;

    always @(negedge clk) begin
        if (bus_if.rden) begin
            rd_cnt++;
            last_rdaddr = bus_if.rdaddress;
        end
        if (bus_if.wren) begin
            wr_cnt++;
            last_wraddr = bus_if.wraddress;
            last_wdata  = bus_if.wdata;
            last_be     = bus_if.wrbyteena;
        end
    end

    // UART transmitter model: records each requested byte and acks it after
    // ack_delay cycles (0 = ack in the same cycle as the request).
    int         ack_delay = 2;
    logic [7:0] tx_q[$];
    int         proto_err = 0;
    bit         pending = 1'b0;
    int         ack_timer = 0;

    initial bus_if.tx_data_ack = 1'b0;

    always @(negedge clk) begin
        bus_if.tx_data_ack = 1'b0;
        if (pending) begin
            if (ack_timer == 0) begin
                bus_if.tx_data_ack = 1'b1;
                pending = 1'b0;
            end else begin
                ack_timer--;
            end
        end
        if (bus_if.tx_data_valid) begin
            if (pending) proto_err++;
            tx_q.push_back(bus_if.tx_data);
            if (ack_delay == 0) begin
                bus_if.tx_data_ack = 1'b1;
            end else begin
                pending   = 1'b1;
                ack_timer = ack_delay - 1;
            end
        end
    end

    typedef struct packed {
        logic [3:0]  n;
        logic [95:0] bytes;
        logic [3:0]  ack_dly;
        logic [1:0]  exp_rd;
        logic [1:0]  exp_wr;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [2:0]  exp_ntx;
        logic [31:0] exp_tx;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        @(negedge clk);
        bus_if.rx_data       = b;
        bus_if.rx_data_fresh = 1'b1;
        @(negedge clk);
        bus_if.rx_data_fresh = 1'b0;
    endtask

    task automatic waitIdle(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(negedge clk);
            if (!bus_if.busy) done = 1'b1;
        end
        checkOutput("idle_within_budget", 32'(done), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int rd0, wr0, tx0;
        ack_delay = int'(v.ack_dly);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        tx0 = tx_q.size();
        for (int i = 0; i < int'(v.n); i++) sendByte(v.bytes[8*i +: 8]);
        waitIdle(300);
        repeat (3) @(negedge clk);
        checkOutput("rd_strobes", 32'(rd_cnt - rd0), 32'(v.exp_rd));
        checkOutput("wr_strobes", 32'(wr_cnt - wr0), 32'(v.exp_wr));
        if (v.exp_rd != 0) checkOutput("rdaddress", last_rdaddr, v.exp_addr);
        if (v.exp_wr != 0) begin
            checkOutput("wraddress", last_wraddr, v.exp_addr);
            checkOutput("wdata", last_wdata, v.exp_wdata);
            checkOutput("wrbyteena", 32'(last_be), 32'hF);
        end
        checkOutput("tx_count", 32'(tx_q.size() - tx0), 32'(v.exp_ntx));
        for (int k = 0; k < int'(v.exp_ntx); k++) begin
            if (tx0 + k < tx_q.size())
                checkOutput("tx_byte", 32'(tx_q[tx0 + k]), 32'(v.exp_tx[8*k +: 8]));
            else
                checkOutput("tx_byte_missing", 32'hFFFF_FFFF, 32'(v.exp_tx[8*k +: 8]));
        end
        checkOutput("busy_after", 32'(bus_if.busy), 32'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int rd0, wr0, tx0;
        bit seen;

        vecs[0] = '{n: 4'd5, bytes: 96'h00_02_00_00_52, ack_dly: 4'd3,
                    exp_rd: 2'd1, exp_wr: 2'd0, exp_addr: 32'h0002_0000,
                    exp_wdata: 32'h0, exp_ntx: 3'd4, exp_tx: 32'h0000_00A5};
        vecs[1] = '{n: 4'd9, bytes: 96'hDE_AD_BE_EF_00_00_00_10_57, ack_dly: 4'd2,
                    exp_rd: 2'd0, exp_wr: 2'd1, exp_addr: 32'h0000_0010,
                    exp_wdata: 32'hDEAD_BEEF, exp_ntx: 3'd1, exp_tx: 32'h0000_004B};
        vecs[2] = '{n: 4'd8, bytes: 96'h00_02_00_00_52_41_FF_00, ack_dly: 4'd1,
                    exp_rd: 2'd1, exp_wr: 2'd0, exp_addr: 32'h0002_0000,
                    exp_wdata: 32'h0, exp_ntx: 3'd4, exp_tx: 32'h0000_00A5};
        vecs[3] = '{n: 4'd5, bytes: 96'h00_00_00_04_52, ack_dly: 4'd0,
                    exp_rd: 2'd1, exp_wr: 2'd0, exp_addr: 32'h0000_0004,
                    exp_wdata: 32'h0, exp_ntx: 3'd4, exp_tx: 32'h0004_C0DE};
        vecs[4] = '{n: 4'd9, bytes: 96'h11_22_33_44_12_34_56_78_57, ack_dly: 4'd0,
                    exp_rd: 2'd0, exp_wr: 2'd1, exp_addr: 32'h1234_5678,
                    exp_wdata: 32'h1122_3344, exp_ntx: 3'd1, exp_tx: 32'h0000_004B};

        bus_if.rx_data       = 8'h00;
        bus_if.rx_data_fresh = 1'b0;
        resetn               = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(bus_if.busy), 32'd0);
        checkOutput("reset_rden", 32'(bus_if.rden), 32'd0);
        checkOutput("reset_wren", 32'(bus_if.wren), 32'd0);
        checkOutput("reset_tx_valid", 32'(bus_if.tx_data_valid), 32'd0);
        checkOutput("reset_tx_data", 32'(bus_if.tx_data), 32'd0);
        checkOutput("reset_rdaddress", bus_if.rdaddress, 32'd0);
        checkOutput("reset_wdata", bus_if.wdata, 32'd0);
        checkOutput("reset_wrbyteena", 32'(bus_if.wrbyteena), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        // A write command byte arriving while the read response is pending
        // must be dropped.
        ack_delay = 6;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        tx0 = tx_q.size();
        sendByte(8'h52); sendByte(8'h00); sendByte(8'h00); sendByte(8'h02); sendByte(8'h00);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (tx_q.size() > tx0) seen = 1'b1;
        end
        checkOutput("drop_resp_started", 32'(seen), 32'd1);
        sendByte(8'h57);
        waitIdle(300);
        repeat (5) @(negedge clk);
        checkOutput("drop_busy_after", 32'(bus_if.busy), 32'd0);
        checkOutput("drop_rd_strobes", 32'(rd_cnt - rd0), 32'd1);
        checkOutput("drop_wr_strobes", 32'(wr_cnt - wr0), 32'd0);
        checkOutput("drop_tx_count", 32'(tx_q.size() - tx0), 32'd4);
        if (tx_q.size() >= tx0 + 4) begin
            checkOutput("drop_tx_byte0", 32'(tx_q[tx0]), 32'hA5);
            checkOutput("drop_tx_byte3", 32'(tx_q[tx0 + 3]), 32'h00);
        end

        // Reset after three address bytes of a write, then a fresh write.
        ack_delay = 2;
        wr0 = wr_cnt;
        tx0 = tx_q.size();
        sendByte(8'h57); sendByte(8'hAA); sendByte(8'hBB); sendByte(8'hCC);
        checkOutput("midframe_busy", 32'(bus_if.busy), 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(bus_if.busy), 32'd0);
        checkOutput("midreset_wraddress", bus_if.wraddress, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        sendByte(8'h57); sendByte(8'h40); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
        sendByte(8'h78); sendByte(8'h56); sendByte(8'h34); sendByte(8'h12);
        waitIdle(300);
        repeat (3) @(negedge clk);
        checkOutput("postreset_wr_strobes", 32'(wr_cnt - wr0), 32'd1);
        checkOutput("postreset_wraddress", last_wraddr, 32'h0000_0040);
        checkOutput("postreset_wdata", last_wdata, 32'h1234_5678);
        checkOutput("postreset_tx_count", 32'(tx_q.size() - tx0), 32'd1);
        if (tx_q.size() > tx0) checkOutput("postreset_ack", 32'(tx_q[tx0]), 32'h4B);

`ifdef UART_BUS_MASTER_TIMEOUT_EN
        // Abandoned partial read must not contribute bytes to the next frame.
        ack_delay = 1;
        rd0 = rd_cnt;
        sendByte(8'h52); sendByte(8'h01);
        repeat (150) @(negedge clk);
        checkOutput("timeout_busy", 32'(bus_if.busy), 32'd0);
        sendByte(8'h52); sendByte(8'h04); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
        waitIdle(300);
        repeat (3) @(negedge clk);
        checkOutput("timeout_rd_strobes", 32'(rd_cnt - rd0), 32'd1);
        checkOutput("timeout_rdaddress", last_rdaddr, 32'h0000_0004);
`endif

        checkOutput("tx_protocol_errors", 32'(proto_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
